turn_sequencer: RTL and testbench

//   Turn/move controller for the Connect-4 datapath. Accepts a debounced move request plus column,

---
 rtl/turn_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_turn_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Connect-4 turn controller: validates a column request, animates the drop,
// issues one board write, then waits for the winner detector's verdict.
module turn_sequencer #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int ROW_W         = 2,
    parameter int COL_W         = 3,
    parameter int DROP_TICKS    = 8,
    parameter int CHECK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             move_req,
    input  logic [COL_W-1:0] move_col,
    input  logic             check_done,
    input  logic [1:0]       check_result,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic             wr_player,
    output logic             anim_valid,
    output logic [ROW_W-1:0] anim_row,
    output logic             current_player,
    output logic             busy,
    output logic             move_reject,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam int IDX_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TICK_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam int CHK_W  = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
    localparam int CELLS  = ROWS * COLS;
    localparam int MC_W   = $clog2(CELLS + 1);

    localparam logic [COL_W:0]      COLS_C    = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]      ROWS_C    = (ROW_W + 1)'(ROWS);
    localparam logic [ROW_W:0]      H_ONE     = (ROW_W + 1)'(1);
    localparam logic [ROW_W-1:0]    TOP_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]    ROW_ONE   = ROW_W'(1);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(DROP_TICKS - 1);
    localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);
    localparam logic [CHK_W-1:0]    CHK_LAST  = CHK_W'(CHECK_TIMEOUT - 1);
    localparam logic [CHK_W-1:0]    CHK_ONE   = CHK_W'(1);
    localparam logic [MC_W-1:0]     CELLS_C   = MC_W'(CELLS);
    localparam logic [MC_W-1:0]     MC_ONE    = MC_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_MOVE,
        S_VALIDATE,
        S_DROP,
        S_COMMIT,
        S_CHECK,
        S_WIN,
        S_DRAW
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    target_q, target_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [CHK_W-1:0]    chk_cnt_q, chk_cnt_d;
    logic [ROW_W:0]      height_q [COLS];
    logic [ROW_W:0]      height_d [COLS];
    logic [MC_W-1:0]     move_count_q, move_count_d;
    logic                player_q, player_d;
    logic                wr_en_q, wr_en_d;
    logic [ROW_W-1:0]    wr_row_q, wr_row_d;
    logic [COL_W-1:0]    wr_col_q, wr_col_d;
    logic                wr_player_q, wr_player_d;
    logic                anim_valid_q, anim_valid_d;
    logic [ROW_W-1:0]    anim_row_q, anim_row_d;
    logic                busy_q, busy_d;
    logic                move_reject_q, move_reject_d;
    logic                game_over_q, game_over_d;
    logic [1:0]          winner_q, winner_d;
    logic [1:0]          verdict;
    logic [IDX_W-1:0]    col_idx;

    assign col_idx = col_q[IDX_W-1:0];

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        target_d      = target_q;
        tick_d        = tick_q;
        chk_cnt_d     = chk_cnt_q;
        height_d      = height_q;
        move_count_d  = move_count_q;
        player_d      = player_q;
        wr_en_d       = 1'b0;
        wr_row_d      = '0;
        wr_col_d      = '0;
        wr_player_d   = 1'b0;
        anim_valid_d  = anim_valid_q;
        anim_row_d    = anim_row_q;
        move_reject_d = 1'b0;
        winner_d      = winner_q;
        verdict       = 2'b00;

        case (state_q)
            S_WAIT_MOVE: begin
                if (move_req) begin
                    col_d   = move_col;
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (({1'b0, col_q} >= COLS_C) || (height_q[col_idx] >= ROWS_C)) begin
                    move_reject_d = 1'b1;
                    state_d       = S_WAIT_MOVE;
                end else begin
                    target_d     = height_q[col_idx][ROW_W-1:0];
                    anim_row_d   = TOP_ROW;
                    anim_valid_d = 1'b1;
                    tick_d       = '0;
                    state_d      = S_DROP;
                end
            end
            S_DROP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (anim_row_q == target_q) begin
                        // Board write and bookkeeping land together so COMMIT is a single cycle
                        wr_en_d      = 1'b1;
                        wr_row_d     = target_q;
                        wr_col_d     = col_q;
                        wr_player_d  = player_q;
                        anim_valid_d = 1'b0;
                        anim_row_d   = '0;
                        if (height_q[col_idx] < ROWS_C)
                            height_d[col_idx] = height_q[col_idx] + H_ONE;
                        if (move_count_q < CELLS_C)
                            move_count_d = move_count_q + MC_ONE;
                        state_d = S_COMMIT;
                    end else begin
                        anim_row_d = anim_row_q - ROW_ONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            S_COMMIT: begin
                chk_cnt_d = '0;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (check_done || (chk_cnt_q == CHK_LAST)) begin
                    // A timeout resolves as "no win"; result 11 also folds into "no win"
                    verdict = check_done ? check_result : 2'b00;
                    if ((verdict == 2'b01) || (verdict == 2'b10)) begin
                        winner_d = verdict;
                        state_d  = S_WIN;
                    end else if (move_count_q == CELLS_C) begin
                        winner_d = 2'b11;
                        state_d  = S_DRAW;
                    end else begin
                        player_d = ~player_q;
                        state_d  = S_WAIT_MOVE;
                    end
                end else begin
                    chk_cnt_d = chk_cnt_q + CHK_ONE;
                end
            end
            S_WIN, S_DRAW: begin
                state_d = state_q;
            end
            default: state_d = S_WAIT_MOVE;
        endcase

        busy_d      = !((state_d == S_WAIT_MOVE) || (state_d == S_WIN) || (state_d == S_DRAW));
        game_over_d = (state_d == S_WIN) || (state_d == S_DRAW);
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q       <= S_WAIT_MOVE;
            col_q         <= '0;
            target_q      <= '0;
            tick_q        <= '0;
            chk_cnt_q     <= '0;
            height_q      <= '{default: '0};
            move_count_q  <= '0;
            player_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_row_q      <= '0;
            wr_col_q      <= '0;
            wr_player_q   <= 1'b0;
            anim_valid_q  <= 1'b0;
            anim_row_q    <= '0;
            busy_q        <= 1'b0;
            move_reject_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            target_q      <= target_d;
            tick_q        <= tick_d;
            chk_cnt_q     <= chk_cnt_d;
            height_q      <= height_d;
            move_count_q  <= move_count_d;
            player_q      <= player_d;
            wr_en_q       <= wr_en_d;
            wr_row_q      <= wr_row_d;
            wr_col_q      <= wr_col_d;
            wr_player_q   <= wr_player_d;
            anim_valid_q  <= anim_valid_d;
            anim_row_q    <= anim_row_d;
            busy_q        <= busy_d;
            move_reject_q <= move_reject_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_row         = wr_row_q;
    assign wr_col         = wr_col_q;
    assign wr_player      = wr_player_q;
    assign anim_valid     = anim_valid_q;
    assign anim_row       = anim_row_q;
    assign current_player = player_q;
    assign busy           = busy_q;
    assign move_reject    = move_reject_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: expected board writes are queued when a
// move is driven and compared (content and latency) when wr_en appears.
module tb_turn_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DT   = 2;
    localparam int TO   = 64;

    logic       clk = 1'b0;
    logic       reset, new_game, move_req, check_done;
    logic [2:0] move_col;
    logic [1:0] check_result;
    logic       wr_en, wr_player, anim_valid, current_player, busy, move_reject, game_over;
    logic [1:0] wr_row, anim_row, winner;
    logic [2:0] wr_col;

    turn_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(2), .COL_W(3),
        .DROP_TICKS(DT), .CHECK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_req(move_req), .move_col(move_col),
        .check_done(check_done), .check_result(check_result),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player),
        .anim_valid(anim_valid), .anim_row(anim_row),
        .current_player(current_player), .busy(busy), .move_reject(move_reject),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] row;
        logic [2:0] col;
        logic       player;
        int         at;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int         m_h [COLS];
    logic       m_player;
    int         m_moves;
    logic       m_over;
    logic [1:0] m_winner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_row", 32'(wr_row), 32'(mon_e.row));
                chk("wr_col", 32'(wr_col), 32'(mon_e.col));
                chk("wr_player", 32'(wr_player), 32'(mon_e.player));
                chk("wr_latency", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (m_h[i]) m_h[i] = 0;
        m_player = 1'b0;
        m_moves  = 0;
        m_over   = 1'b0;
        m_winner = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 32'({wr_en, wr_row, wr_col, wr_player, anim_valid, anim_row,
                      current_player, busy, move_reject, game_over, winner}), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_player"}, 32'(current_player), 32'(m_player));
        chk({tag, "_game_over"}, 32'(game_over), 32'(m_over));
        chk({tag, "_winner"}, 32'(winner), 32'(m_winner));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_anim_valid"}, 32'(anim_valid), 32'd0);
    endtask

    task automatic drive_req(input logic [2:0] col);
        move_req = 1'b1;
        move_col = col;
        step();
        move_req = 1'b0;
        move_col = '0;
    endtask

    // mode: 0 plain, 1 check animation, 2 extra request during drop,
    //       3 stray check_done in the commit cycle, 4 withhold check_done
    task automatic legal_move(input int col, input logic [1:0] verdict, input int mode);
        wr_t        e;
        int         waited;
        int         drop_len;
        logic [1:0] v;
        drop_len = (ROWS - m_h[col]) * DT;
        e.row    = 2'(m_h[col]);
        e.col    = 3'(col);
        e.player = m_player;
        e.at     = cyc + 2 + drop_len;
        exp_q.push_back(e);
        drive_req(3'(col));
        if (mode == 1) begin
            chk("validate_anim_valid", 32'(anim_valid), 32'd0);
            chk("validate_busy", 32'(busy), 32'd1);
            for (int i = 0; i < drop_len; i++) begin
                step();
                chk("anim_row", 32'(anim_row), 32'(ROWS - 1 - i / DT));
                chk("anim_valid", 32'(anim_valid), 32'd1);
            end
        end
        if (mode == 2) begin
            step();
            step();
            move_req = 1'b1;
            move_col = 3'd3;
            step();
            move_req = 1'b0;
            move_col = '0;
        end
        waited = 0;
        while (wr_en !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        chk("wr_seen", 32'(wr_en), 32'd1);
        if (mode == 3) begin
            check_done   = 1'b1;
            check_result = 2'b10;
            step();
            check_done   = 1'b0;
            check_result = 2'b00;
        end else begin
            step();
        end
        if (mode == 4) begin
            for (int i = 1; i < TO; i++) step();
            chk("timeout_busy", 32'(busy), 32'd1);
            chk("timeout_player", 32'(current_player), 32'(m_player));
            step();
            v = 2'b00;
        end else begin
            check_done   = 1'b1;
            check_result = verdict;
            step();
            check_done   = 1'b0;
            check_result = 2'b00;
            v = verdict;
        end
        m_h[col]++;
        m_moves++;
        if (v == 2'b01 || v == 2'b10) begin
            m_over   = 1'b1;
            m_winner = v;
        end else if (m_moves == ROWS * COLS) begin
            m_over   = 1'b1;
            m_winner = 2'b11;
        end else begin
            m_player = ~m_player;
        end
        check_idle("after_move");
    endtask

    task automatic reject_move(input logic [2:0] col);
        drive_req(col);
        step();
        chk("reject_pulse", 32'(move_reject), 32'd1);
        chk("reject_busy", 32'(busy), 32'd0);
        chk("reject_player", 32'(current_player), 32'(m_player));
        step();
        chk("reject_one_cycle", 32'(move_reject), 32'd0);
    endtask

    task automatic over_ignores_move(input logic [2:0] col);
        drive_req(col);
        step();
        step();
        chk("over_no_reject", 32'(move_reject), 32'd0);
        chk("over_busy", 32'(busy), 32'd0);
        chk("over_game_over", 32'(game_over), 32'd1);
        chk("over_winner", 32'(winner), 32'(m_winner));
    endtask

    initial begin
        reset        = 1'b1;
        new_game     = 1'b0;
        move_req     = 1'b0;
        move_col     = '0;
        check_done   = 1'b0;
        check_result = 2'b00;
        model_clear();
        step();
        step();
        check_all_zero("reset_outputs");
        reset = 1'b0;
        step();
        check_all_zero("idle_after_reset");

        // First game: animation, column fill, rejects, ignored requests, win
        legal_move(1, 2'b00, 1);
        for (int i = 0; i < ROWS; i++) legal_move(2, 2'b00, 0);
        reject_move(3'd2);
        reject_move(3'd5);
        legal_move(0, 2'b00, 2);
        legal_move(3, 2'b11, 3);
        legal_move(0, 2'b10, 0);
        over_ignores_move(3'd1);

        new_game = 1'b1;
        step();
        check_all_zero("new_game_outputs");
        new_game = 1'b0;
        model_clear();

        // Second game: fill the board to a draw, one verdict withheld
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                legal_move(c, 2'b00, (c == 1 && r == 2) ? 4 : 0);
        over_ignores_move(3'd0);

        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();

        // Reset in the middle of a drop
        legal_move(1, 2'b00, 0);
        drive_req(3'd1);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check_all_zero("reset_mid_drop");
        reset = 1'b0;
        model_clear();
        step();
        chk("post_reset_anim", 32'(anim_valid), 32'd0);
        legal_move(1, 2'b00, 0);

        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
